traffic_phase_ctrl: RTL

//  Parametrised N-road traffic signal controller; successor to the fixed 2-road sequencer.

---
 rtl/traffic_phase_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-road round-robin GREEN->YELLOW->ALL-RED signal controller with a
// tick prescaler, actuated green extension / empty-road skipping and a flashing-yellow override.
module traffic_phase_ctrl #(
   parameter int NUM_ROADS = 3,
   parameter int TICK_DIV  = 4,
   parameter int CNT_W     = 8,
   parameter int GREEN_T   = 10,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   mode_act,
   input  logic                   flash,
   input  logic [NUM_ROADS-1:0]   veh_req,
   output logic [3*NUM_ROADS-1:0] road_out,
   output logic [2:0]             active_road,
   output logic                   phase_done,
   output logic [3*NUM_ROADS-1:0] io_oeb
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

   localparam logic [2:0] LAMP_RED = 3'b001;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GREEN,
      S_YELLOW,
      S_ALLRED,
      S_FLASH
   } state_t;

   state_t           state;
   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] timer;
   logic             resume_zero;
   logic             tick;
   logic             other_req;
   logic             found_req;
   logic [2:0]       next_road;

   assign tick   = (pre == PRE_LAST);
   assign io_oeb = '0;

   always_comb begin
      other_req = 1'b0;
      for (int i = 0; i < NUM_ROADS; i++) begin
         if (veh_req[i] && (active_road != 3'(i))) other_req = 1'b1;
      end
   end

   // Actuated: first requesting road after the current one (wrapping back to itself);
   // with no demand at all, or in fixed mode, simply the successor.
   always_comb begin
      found_req = 1'b0;
      next_road = (active_road == 3'(NUM_ROADS - 1)) ? 3'd0 : active_road + 3'd1;
      if (mode_act) begin
         for (int k = 1; k <= NUM_ROADS; k++) begin
            for (int i = 0; i < NUM_ROADS; i++) begin
               if (!found_req && veh_req[i] && (((int'(active_road) + k) % NUM_ROADS) == i)) begin
                  next_road = 3'(i);
                  found_req = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      road_out = '0;
      for (int i = 0; i < NUM_ROADS; i++) begin
         case (state)
            S_GREEN:  road_out[3*i +: 3] = (active_road == 3'(i)) ? LAMP_GRN : LAMP_RED;
            S_YELLOW: road_out[3*i +: 3] = (active_road == 3'(i)) ? LAMP_YEL : LAMP_RED;
            S_FLASH:  road_out[3*i +: 3] = timer[0] ? LAMP_RED : LAMP_YEL;
            default:  road_out[3*i +: 3] = LAMP_RED;
         endcase
      end
   end

   // NOTE: every register here uses <= so all decisions in one edge see pre-edge values;
   // a later assignment in the same edge (state entry, green hold) overrides the default advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         active_road <= 3'd0;
         pre         <= '0;
         timer       <= '0;
         phase_done  <= 1'b0;
         resume_zero <= 1'b0;
      end else begin
         phase_done <= 1'b0;
         if (tick) begin
            pre   <= '0;
            timer <= timer + CNT_W'(1);
         end else begin
            pre <= pre + PRE_W'(1);
         end

         if (flash && (state != S_FLASH)) begin
            state <= S_FLASH;
            pre   <= '0;
            timer <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (enable) begin
                     state       <= S_GREEN;
                     active_road <= 3'd0;
                     pre         <= '0;
                     timer       <= '0;
                  end
               end
               S_GREEN: begin
                  if (tick && (!enable || ((timer == GREEN_LAST) && (!mode_act || other_req)))) begin
                     state <= S_YELLOW;
                     pre   <= '0;
                     timer <= '0;
                  end else if (tick && (timer == GREEN_LAST)) begin
                     timer <= timer;  // actuated hold: minimum green served, no competing demand
                  end
               end
               S_YELLOW: begin
                  if (tick && (timer == YELLOW_LAST)) begin
                     state <= S_ALLRED;
                     pre   <= '0;
                     timer <= '0;
                  end
               end
               S_ALLRED: begin
                  if (tick && (timer == ALLRED_LAST)) begin
                     pre         <= '0;
                     timer       <= '0;
                     resume_zero <= 1'b0;
                     if (!enable) begin
                        state <= S_IDLE;
                     end else begin
                        state       <= S_GREEN;
                        active_road <= resume_zero ? 3'd0 : next_road;
                        phase_done  <= 1'b1;
                     end
                  end
               end
               S_FLASH: begin
                  if (!flash) begin
                     state       <= S_ALLRED;
                     pre         <= '0;
                     timer       <= '0;
                     resume_zero <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
